// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and constants
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} fetch_state_t;
  localparam int unsigned PC_INCR = 4;
  localparam logic [31:0] NOP_INSTR = '0;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry instruction/pc holding register with load and clear
module fetch_skid_buf #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o
);
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;
  always_ff @(posedge clk) begin
    if (clear_i) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner and imem req/ack fetcher feeding IF/ID with bubbles on empty cycles
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_next_pc,
  output logic               if_valid
);
  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, tgt_q, tgt_d, if_pc_q, if_pc_d, pend_pc;
  logic [INSTR_W-1:0] instr_q, instr_d, pend_instr;
  logic               valid_q, valid_d, pend_load;
  logic [ADDR_W-1:0]  pc_inc;
  logic [INSTR_W-1:0] nop;
  assign pc_inc = pc_q + ADDR_W'(PC_INCR);
  assign nop    = INSTR_W'(NOP_INSTR);
  fetch_skid_buf #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_skid (
    .clk     (clk),
    .clear_i (!rst_n),
    .load_i  (pend_load),
    .instr_i (imem_rdata),
    .pc_i    (pc_q),
    .instr_o (pend_instr),
    .pc_o    (pend_pc)
  );
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    instr_d   = instr_q;
    if_pc_d   = if_pc_q;
    valid_d   = valid_q;
    pend_load = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          instr_d = nop;
          // without an ack the address must stay put until the stale fetch drains
          if (imem_ack) pc_d = redirect_pc;
          else begin
            tgt_d   = redirect_pc;
            state_d = DISCARD;
          end
        end else if (imem_ack && stall && valid_q) begin
          pend_load = 1'b1;
          pc_d      = pc_inc;
          state_d   = HOLD;
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          if_pc_d = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_inc;
        end else if (!stall) begin
          valid_d = 1'b0;
          instr_d = nop;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          instr_d = nop;
          state_d = REQ;
        end else if (!stall) begin
          instr_d = pend_instr;
          if_pc_d = pend_pc;
          valid_d = 1'b1;
          state_d = REQ;
        end
      end
      DISCARD: begin
        tgt_d = redirect_valid ? redirect_pc : tgt_q;
        if (imem_ack) begin
          pc_d    = redirect_valid ? redirect_pc : tgt_q;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      instr_q <= '0;
      if_pc_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      if_pc_q <= if_pc_d;
      valid_q <= valid_d;
    end
  end
  assign imem_req       = rst_n && (state_q == REQ || state_q == DISCARD);
  assign imem_addr      = pc_q;
  assign if_instruction = instr_q;
  assign if_pc          = if_pc_q;
  assign if_next_pc     = if_pc_q + ADDR_W'(PC_INCR);
  assign if_valid       = valid_q;
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC and issues requests to instruction memory over a req/ack handshake that tolerates wait states. It delivers the fetched instruction, its PC and the next sequential PC to IF/ID, and absorbs stalls from decode and redirects (branch/jump/ret) from later stages. Unfilled cycles are emitted as bubbles, with the instruction forced to 0 (NOP), because IF/ID has no valid bit.

Parameters:
ADDR_W, 32, width of PC and instruction-memory address
INSTR_W, 32, instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  reset, synchronous, active-low
stall  in  1  decode hazard; IF/ID does not load while 1 (IF/ID enable = !stall)
redirect_valid  in  1  later stage requests a PC change this cycle
redirect_pc  in  ADDR_W  redirect target
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address, stable while imem_req=1 and not acked
imem_ack  in  1  memory returns data this cycle; only valid while imem_req=1
imem_rdata  in  INSTR_W  instruction, valid with imem_ack
if_instruction  out  INSTR_W  instruction to IF/ID; 0 when if_valid=0
if_pc  out  ADDR_W  PC of if_instruction
if_next_pc  out  ADDR_W  if_pc+4, mod 2^ADDR_W
if_valid  out  1  output holds a real instruction

Behaviour:
- Reset: on posedge with rst_n=0, the block sets state=IDLE, pc=RESET_PC and tgt=0, and clears if_instruction, if_pc and if_valid. imem_req=0 whenever rst_n=0 or state=IDLE. Reset wins over everything, including mid-transaction; an ack arriving during reset is ignored.
- Registers: pc (current fetch address), tgt (pending redirect target), pend_instr/pend_pc (skid entry), and output registers. imem_addr=pc.
- Arithmetic: PC increments by 4 and wraps modulo 2^ADDR_W. Redirect targets are used unaligned as given.
- Latency: ack in cycle N -> if_valid=1 with that data in cycle N+1 (when not stalled). Zero-wait ack (ack in the first req cycle) is legal.
- IDLE: imem_req=0. Go to REQ next cycle.
- REQ: imem_req=1. Priority order, first match wins:
  - redirect_valid: pc<=redirect_pc, if_valid<=0, if_instruction<=0.
    - ack also present: the returned data is dropped; stay in REQ.
    - no ack: tgt<=redirect_pc; keep pc unchanged (address must stay stable); go to DISCARD.
  - ack and stall and if_valid: pend_instr<=rdata, pend_pc<=pc, pc<=pc+4; outputs held; go to HOLD.
  - ack (not blocked): if_instruction<=rdata, if_pc<=pc, if_valid<=1, pc<=pc+4; stay in REQ.
  - no ack and stall: outputs held.
  - no ack, no stall: bubble (if_valid<=0, if_instruction<=0).
- HOLD: imem_req=0; outputs held.
  - redirect_valid: pend dropped, pc<=redirect_pc, bubble; go to REQ.
  - stall=0: outputs<=pend, if_valid<=1; go to REQ.
- DISCARD: imem_req=1 at the old pc; if_valid=0.
  - A further redirect_valid overwrites tgt (latest redirect wins).
  - On ack: data dropped, pc<=tgt (or redirect_pc if redirect_valid is present that same cycle); go to REQ.
- Redirect has priority over stall in every state. Redirect and ack in the same cycle never deliver the acked data.
- stall while if_valid=0 does not block capture; the bubble is overwritten.

Decomposition:
- Shared package cpu_pkg:
  - fetch_state_t enum {IDLE, REQ, HOLD, DISCARD}
  - PC_INCR=4
  - NOP_INSTR='0
- Sub-module fetch_skid_buf: one-entry instr/pc holding register with load/clear, used for pend_*.
- Expected RTL size: ~200 lines total.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles, RESET_PC=0 -> imem_req=0 throughout reset and the following IDLE cycle; all outputs 0; then imem_req=1, imem_addr=0.
2. Zero-wait stream: ack every cycle with rdata 0x11, 0x22, 0x33 -> if_valid=1 starting one cycle after the first ack; (if_pc, instr) = (0,0x11), (4,0x22), (8,0x33); if_next_pc=4, 8, 12.
3. Wait states: ack for addr 4 delayed 3 cycles -> imem_addr stays 4 for 4 cycles; if_valid=0 and if_instruction=0 during the gap; then (4, rdata).
4. Stall skid: outputs (0,0x11) valid, stall=1, ack returns 0x22 -> HOLD with imem_req=0 and outputs held at 0x11; stall=0 -> next cycle (4,0x22) valid; next imem_addr=8.
5. Redirect with outstanding request: req at addr 8 unacked, redirect_pc=0x100 -> DISCARD, addr stays 8; ack 0xDEAD is dropped; next cycle imem_addr=0x100; if_valid=0 until the 0x100 data is delivered. Repeat with a second redirect 0x200 during DISCARD -> fetch resumes at 0x200.
6. Boundaries:
   - redirect+stall in HOLD -> pend discarded, fetch at target.
   - rst_n=0 during DISCARD -> next fetch at RESET_PC.
   - pc=0xFFFF_FFFC acked -> next imem_addr=0, if_next_pc=0.
